// File: rtl/otn_frame_rx_pkg.sv
// Shared types and helpers for the OTN frame receiver: FSM encoding,
// default frame-start pattern, ack symbol bits and sync-byte extraction.
package otn_rx_pkg;

    typedef enum logic [2:0] {
        ST_HUNT     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_DATA     = 3'd2,
        ST_WAIT_CRC = 3'd3,
        ST_ACK      = 3'd4
    } state_e;

    localparam logic [63:0] DEF_SYNC_PATTERN = 64'h0000_F6F6_F628_2828;

    localparam logic ACK_START = 1'b0;
    localparam logic ACK_STOP  = 1'b0;
    localparam logic ACK_IDLE  = 1'b1;

    // Byte idx of a right-justified pattern; idx 0 is the most significant used byte.
    function automatic logic [7:0] sync_byte(input logic [63:0] pattern,
                                             input int          nbytes,
                                             input int          idx);
        logic [63:0] shifted;
        shifted = pattern >> (8 * (nbytes - 1 - idx));
        return shifted[7:0];
    endfunction

    function automatic logic ack_bit(input logic [1:0] idx, input logic good);
        logic b;
        case (idx)
            2'd0:    b = ACK_START;
            2'd1:    b = good;
            2'd2:    b = ACK_STOP;
            default: b = ACK_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/otn_frame_rx_if.sv
// Payload byte stream from the receiver to the demapper (valid/ready with SOF/EOF).
interface otn_frame_rx_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_sof;
    logic       o_eof;
    logic       i_ready;

    modport master (output o_data, output o_valid, output o_sof, output o_eof, input i_ready);
    modport slave  (input o_data, input o_valid, input o_sof, input o_eof, output i_ready);
endinterface

// File: rtl/otn_frame_rx_bit_timer.sv
// Serial line synchronizer and oversampling bit-phase tracker; produces a
// mid-bit sample strobe and an end-of-bit-period strobe.
module otn_bit_timer #(
    parameter int OVERSAMPLE = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sample_en,
    input  logic i_serial_rx,
    input  logic i_hunt,
    input  logic i_restart,
    output logic o_rx_bit,
    output logic o_bit_stb,
    output logic o_bit_end
);
    localparam int              PH_W    = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

    logic [1:0]      sync_q, sync_d;
    logic            last_q, last_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            edge_s;

    // Next-state: while hunting, every line transition re-centres the bit phase.
    always_comb begin
        sync_d  = {sync_q[0], i_serial_rx};
        last_d  = sync_q[1];
        edge_s  = (sync_q[1] != last_q);
        phase_d = phase_q;
        if (i_restart || (i_hunt && edge_s)) begin
            phase_d = '0;
        end else if (i_sample_en) begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // State registers; the line idles high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= 2'b11;
            last_q  <= 1'b1;
            phase_q <= '0;
        end else begin
            sync_q  <= sync_d;
            last_q  <= last_d;
            phase_q <= phase_d;
        end
    end

    assign o_rx_bit  = sync_q[1];
    assign o_bit_stb = i_sample_en && (phase_q == PH_MID);
    assign o_bit_end = i_sample_en && (phase_q == PH_LAST);

endmodule

// File: rtl/otn_frame_rx.sv
// OTN serial frame receiver: hunts for the frame-start pattern, streams the
// payload bytes out and optionally returns an ARQ good/bad ack symbol.
module otn_frame_rx
    import otn_rx_pkg::*;
#(
    parameter int          OVERSAMPLE   = 20,
    parameter int          SYNC_BYTES   = 6,
    parameter logic [63:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
    parameter int          FRAME_BYTES  = 4160,
    parameter int          CRC_TIMEOUT  = 1024,
    parameter int          CNT_W        = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sample_en,
    input  logic                 i_serial_rx,
    input  logic                 i_arq_en,
    input  logic                 i_arq_en_valid,
    input  logic                 i_crc_err,
    input  logic                 i_crc_err_valid,
    otn_frame_rx_if.master       stream,
    output logic                 o_ack_tx,
    output logic [2:0]           o_state,
    output logic [CNT_W-1:0]     o_frame_cnt,
    output logic [CNT_W-1:0]     o_sync_err_cnt,
    output logic                 o_overflow
);
    localparam int               BYTE_W    = $clog2(FRAME_BYTES);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);
    localparam logic [2:0]       LAST_SYNC = 3'(SYNC_BYTES - 1);
    localparam int               TMR_W     = $clog2(CRC_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CRC_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [2:0]         sync_idx_q, sync_idx_d;
    logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [TMR_W-1:0]   crc_tmr_q, crc_tmr_d;
    logic               arq_en_q, arq_en_d;
    logic               ack_good_q, ack_good_d;
    logic [1:0]         ack_idx_q, ack_idx_d;
    logic               ack_tx_q, ack_tx_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   sync_err_cnt_q, sync_err_cnt_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;

    logic rx_bit_s, bit_stb_s, bit_end_s, restart_s, byte_done_s, hunt_s;

    assign hunt_s = (state_q == ST_HUNT);

    otn_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sample_en (i_sample_en),
        .i_serial_rx (i_serial_rx),
        .i_hunt      (hunt_s),
        .i_restart   (restart_s),
        .o_rx_bit    (rx_bit_s),
        .o_bit_stb   (bit_stb_s),
        .o_bit_end   (bit_end_s)
    );

    // Framing FSM, counters and output stage next-state logic.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        sync_idx_d     = sync_idx_q;
        byte_cnt_d     = byte_cnt_q;
        crc_tmr_d      = crc_tmr_q;
        ack_good_d     = ack_good_q;
        ack_idx_d      = ack_idx_q;
        ack_tx_d       = ack_tx_q;
        frame_cnt_d    = frame_cnt_q;
        sync_err_cnt_d = sync_err_cnt_q;
        overflow_d     = overflow_q;
        data_d         = data_q;
        sof_d          = sof_q;
        eof_d          = eof_q;
        byte_done_s    = 1'b0;
        restart_s      = 1'b0;
        arq_en_d       = i_arq_en_valid ? i_arq_en : arq_en_q;

        if (bit_stb_s) begin
            shift_d = {shift_q[6:0], rx_bit_s};
        end else begin
            shift_d = shift_q;
        end

        if (valid_q && stream.i_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_HUNT: begin
                if (bit_stb_s && (shift_d == sync_byte(SYNC_PATTERN, SYNC_BYTES, 0))) begin
                    state_d    = ST_SYNC;
                    bit_cnt_d  = 3'd0;
                    sync_idx_d = 3'd1;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_SYNC: begin
                if (bit_stb_s && (bit_cnt_q == 3'd7)) begin
                    bit_cnt_d = 3'd0;
                    if (shift_d != sync_byte(SYNC_PATTERN, SYNC_BYTES, int'(sync_idx_q))) begin
                        state_d = ST_HUNT;
                        if (sync_err_cnt_q != {CNT_W{1'b1}}) begin
                            sync_err_cnt_d = sync_err_cnt_q + CNT_W'(1);
                        end else begin
                            sync_err_cnt_d = sync_err_cnt_q;
                        end
                    end else if (sync_idx_q == LAST_SYNC) begin
                        state_d    = ST_DATA;
                        byte_cnt_d = '0;
                    end else begin
                        sync_idx_d = sync_idx_q + 3'd1;
                    end
                end else if (bit_stb_s) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_DATA: begin
                if (bit_stb_s && (bit_cnt_q == 3'd7)) begin
                    bit_cnt_d   = 3'd0;
                    byte_done_s = 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        byte_cnt_d  = '0;
                        crc_tmr_d   = '0;
                        state_d     = arq_en_d ? ST_WAIT_CRC : ST_HUNT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                    end
                end else if (bit_stb_s) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_WAIT_CRC: begin
                // A verdict arriving on the timeout cycle takes priority over the timeout.
                if (i_crc_err_valid) begin
                    ack_good_d = ~i_crc_err;
                    state_d    = ST_ACK;
                end else if (crc_tmr_q == TMR_LAST) begin
                    ack_good_d = 1'b0;
                    state_d    = ST_ACK;
                end else begin
                    crc_tmr_d = crc_tmr_q + TMR_W'(1);
                end
            end
            ST_ACK: begin
                if (bit_end_s && (ack_idx_q == 2'd3)) begin
                    state_d  = ST_HUNT;
                    ack_tx_d = ACK_IDLE;
                end else if (bit_end_s) begin
                    ack_idx_d = ack_idx_q + 2'd1;
                    ack_tx_d  = ack_bit(ack_idx_q + 2'd1, ack_good_q);
                end else begin
                    ack_tx_d = ack_tx_q;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // Start bit goes out on the first ACK cycle; the bit period restarts there too.
        if ((state_q != ST_ACK) && (state_d == ST_ACK)) begin
            restart_s = 1'b1;
            ack_idx_d = 2'd0;
            ack_tx_d  = ACK_START;
        end else begin
            restart_s = 1'b0;
        end

        if (byte_done_s && valid_q && !stream.i_ready) begin
            overflow_d = 1'b1;
        end else if (byte_done_s) begin
            data_d  = shift_d;
            valid_d = 1'b1;
            sof_d   = (byte_cnt_q == '0);
            eof_d   = (byte_cnt_q == LAST_BYTE);
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_HUNT;
            shift_q        <= 8'h00;
            bit_cnt_q      <= 3'd0;
            sync_idx_q     <= 3'd0;
            byte_cnt_q     <= '0;
            crc_tmr_q      <= '0;
            arq_en_q       <= 1'b0;
            ack_good_q     <= 1'b0;
            ack_idx_q      <= 2'd0;
            ack_tx_q       <= ACK_IDLE;
            frame_cnt_q    <= '0;
            sync_err_cnt_q <= '0;
            overflow_q     <= 1'b0;
            data_q         <= 8'h00;
            valid_q        <= 1'b0;
            sof_q          <= 1'b0;
            eof_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            sync_idx_q     <= sync_idx_d;
            byte_cnt_q     <= byte_cnt_d;
            crc_tmr_q      <= crc_tmr_d;
            arq_en_q       <= arq_en_d;
            ack_good_q     <= ack_good_d;
            ack_idx_q      <= ack_idx_d;
            ack_tx_q       <= ack_tx_d;
            frame_cnt_q    <= frame_cnt_d;
            sync_err_cnt_q <= sync_err_cnt_d;
            overflow_q     <= overflow_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            sof_q          <= sof_d;
            eof_q          <= eof_d;
        end
    end

    assign stream.o_data  = data_q;
    assign stream.o_valid = valid_q;
    assign stream.o_sof   = sof_q;
    assign stream.o_eof   = eof_q;
    assign o_ack_tx       = ack_tx_q;
    assign o_state        = state_q;
    assign o_frame_cnt    = frame_cnt_q;
    assign o_sync_err_cnt = sync_err_cnt_q;
    assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_otn_frame_rx.sv
// Directed bench for otn_frame_rx: a frame-level model predicts the payload
// beats, a per-cycle monitor checks the stream, literals pin counters and acks.
`timescale 1ns/1ps
module tb_otn_frame_rx;
    localparam int OS = 4;
    localparam int SB = 6;
    localparam int FB = 8;
    localparam int CT = 16;
    localparam int CW = 16;
    localparam int LOG_N = 30000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_en = 1'b1;
    logic serial_rx = 1'b1;
    logic arq_en = 1'b0;
    logic arq_en_valid = 1'b0;
    logic crc_err = 1'b0;
    logic crc_err_valid = 1'b0;
    logic          ack_tx;
    logic [2:0]    state;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] sync_err_cnt;
    logic          overflow;

    otn_frame_rx_if bus ();

    otn_frame_rx #(
        .OVERSAMPLE(OS), .SYNC_BYTES(SB), .SYNC_PATTERN(64'h0000F6F6F6282828),
        .FRAME_BYTES(FB), .CRC_TIMEOUT(CT), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_sample_en(sample_en), .i_serial_rx(serial_rx),
        .i_arq_en(arq_en), .i_arq_en_valid(arq_en_valid), .i_crc_err(crc_err),
        .i_crc_err_valid(crc_err_valid), .stream(bus), .o_ack_tx(ack_tx),
        .o_state(state), .o_frame_cnt(frame_cnt), .o_sync_err_cnt(sync_err_cnt),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] d;
    } beat_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          beats = 0;
    int          ack_low_cnt = 0;
    int          fall_cyc = -1;
    int          wait_cyc = -1;
    beat_t       exp_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  sync_pat[SB] = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28};
    logic        ack_log[LOG_N];
    logic [2:0]  st_log[LOG_N];
    logic        hold_v = 1'b0;
    logic [9:0]  held = 10'h0;
    logic        prev_ack = 1'b1;
    logic [2:0]  prev_st = 3'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Expected beats: a frame yields payload only when its whole sync prefix is right.
    task automatic model_frame(input int keep);
        int ok;
        ok = (tx_q.size() >= SB + FB) ? 1 : 0;
        for (int i = 0; i < SB && ok == 1; i++) begin
            if (tx_q[i] != sync_pat[i]) ok = 0;
        end
        if (ok == 1) begin
            for (int i = 0; i < FB && i < keep; i++) begin
                exp_q.push_back(beat_t'{sof: (i == 0), eof: (i == FB - 1), d: tx_q[SB + i]});
            end
        end
    endtask

    task automatic build_frame(input logic [7:0] seed);
        tx_q.delete();
        for (int i = 0; i < SB; i++) tx_q.push_back(sync_pat[i]);
        for (int i = 0; i < FB; i++) tx_q.push_back(seed + 8'(i));
    endtask

    task automatic send_bit(input logic b);
        serial_rx = b;
        repeat (OS) @(posedge clk);
        #1;
    endtask

    task automatic send_byte_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i >= 8 - nbits; i--) send_bit(b[i]);
    endtask

    task automatic send_range(input int from, input int upto);
        for (int k = from; k < upto; k++) send_byte_bits(tx_q[k], 8);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic pulse_arq(input logic v);
        arq_en = v;
        arq_en_valid = 1'b1;
        @(posedge clk);
        #1;
        arq_en_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim);
        int n;
        n = 0;
        while (state !== s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait state", 32'(state), 32'(s));
    endtask

    task automatic chk_ack(input string nm, input logic good);
        if (fall_cyc < 0 || fall_cyc + 16 >= LOG_N) begin
            chk({nm, " start seen"}, 32'(fall_cyc >= 0), 32'(1'b1));
        end else begin
            chk({nm, " start"}, 32'(ack_log[fall_cyc + 1]), 32'(1'b0));
            chk({nm, " verdict"}, 32'(ack_log[fall_cyc + 5]), 32'(good));
            chk({nm, " stop"}, 32'(ack_log[fall_cyc + 9]), 32'(1'b0));
            chk({nm, " idle"}, 32'(ack_log[fall_cyc + 13]), 32'(1'b1));
            chk({nm, " in ack"}, 32'(st_log[fall_cyc + 15]), 32'(3'd4));
            chk({nm, " back to hunt"}, 32'(st_log[fall_cyc + 16]), 32'(3'd0));
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stream compare and ack/state logging, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            ack_log[cyc] = ack_tx;
            st_log[cyc]  = state;
        end
        if (!ack_tx) ack_low_cnt++;
        if (prev_ack && !ack_tx && fall_cyc < 0) fall_cyc = cyc;
        if (state == 3'd3 && prev_st != 3'd3) wait_cyc = cyc;
        prev_ack = ack_tx;
        prev_st  = state;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold valid", 32'(bus.o_valid), 32'(1'b1));
                chk("hold beat", 32'({bus.o_sof, bus.o_eof, bus.o_data}), 32'(held));
            end
            if (bus.o_valid && bus.i_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected beat: got %0h want none", bus.o_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat", 32'({bus.o_sof, bus.o_eof, bus.o_data}), 32'(e));
                end
            end
            hold_v = bus.o_valid && !bus.i_ready;
            held   = {bus.o_sof, bus.o_eof, bus.o_data};
        end
    end

    initial begin
        int low0;
        int ofs;
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst valid", 32'(bus.o_valid), 32'(1'b0));
        chk("rst ack", 32'(ack_tx), 32'(1'b1));
        chk("rst state", 32'(state), 32'(3'd0));
        chk("rst frame cnt", 32'(frame_cnt), 32'(16'd0));
        rst = 1'b0;

        // Clean frame, ARQ off.
        build_frame(8'h00);
        model_frame(FB);
        chk("model first", 32'(exp_q[0]), 32'h200);
        chk("model last", 32'(exp_q[FB - 1]), 32'h107);
        low0 = ack_low_cnt;
        send_idle(4);
        send_range(0, SB + FB);
        send_idle(8);
        chk("t1 frame cnt", 32'(frame_cnt), 32'(16'd1));
        chk("t1 beats", 32'(beats), 32'(8));
        chk("t1 exp empty", 32'(exp_q.size()), 32'(0));
        chk("t1 ack idle", 32'(ack_low_cnt - low0), 32'(0));
        chk("t1 state", 32'(state), 32'(3'd0));

        // Broken sync, then a good frame.
        tx_q = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'hAA};
        model_frame(FB);
        send_range(0, 5);
        send_idle(8);
        chk("t2 sync err", 32'(sync_err_cnt), 32'(16'd1));
        chk("t2 state", 32'(state), 32'(3'd0));
        chk("t2 beats", 32'(beats), 32'(8));
        build_frame(8'h30);
        model_frame(FB);
        send_range(0, SB + FB);
        send_idle(8);
        chk("t2 frame cnt", 32'(frame_cnt), 32'(16'd2));
        chk("t2 beats after", 32'(beats), 32'(16));

        // ARQ good then bad verdict.
        pulse_arq(1'b1);
        for (int v = 0; v < 2; v++) begin
            fall_cyc = -1;
            build_frame(8'h90 + 8'(v * 16));
            model_frame(FB);
            send_range(0, SB + FB);
            serial_rx = 1'b1;
            wait_state(3'd3, 60);
            @(posedge clk);
            #1;
            crc_err = (v == 1);
            crc_err_valid = 1'b1;
            @(posedge clk);
            #1;
            crc_err_valid = 1'b0;
            crc_err = 1'b0;
            repeat (60) @(posedge clk);
            #1;
            chk_ack((v == 0) ? "ack good" : "ack bad", (v == 0));
        end
        chk("t3 frame cnt", 32'(frame_cnt), 32'(16'd4));

        // No verdict: timeout forces a bad ack.
        fall_cyc = -1;
        wait_cyc = -1;
        build_frame(8'hC8);
        model_frame(FB);
        send_range(0, SB + FB);
        serial_rx = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        ofs = fall_cyc - wait_cyc;
        chk("timeout delay", 32'(ofs), 32'(CT));
        chk_ack("ack timeout", 1'b0);
        chk("t5 frame cnt", 32'(frame_cnt), 32'(16'd5));
        pulse_arq(1'b0);

        // Stalled sink: only the first byte survives.
        bus.i_ready = 1'b0;
        build_frame(8'h40);
        model_frame(1);
        send_idle(2);
        send_range(0, SB + FB);
        send_idle(4);
        chk("ovf flag", 32'(overflow), 32'(1'b1));
        chk("ovf valid", 32'(bus.o_valid), 32'(1'b1));
        chk("ovf data", 32'(bus.o_data), 32'(8'h40));
        chk("ovf frame cnt", 32'(frame_cnt), 32'(16'd6));
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf released", 32'(bus.o_valid), 32'(1'b0));
        chk("ovf exp empty", 32'(exp_q.size()), 32'(0));

        // Reset in the middle of payload byte 3.
        build_frame(8'h60);
        model_frame(3);
        send_idle(2);
        send_range(0, SB + 3);
        send_byte_bits(tx_q[SB + 3], 4);
        rst = 1'b1;
        serial_rx = 1'b1;
        @(posedge clk);
        #1;
        chk("mid rst valid", 32'(bus.o_valid), 32'(1'b0));
        chk("mid rst flags", 32'({bus.o_sof, bus.o_eof}), 32'(2'b00));
        chk("mid rst data", 32'(bus.o_data), 32'(8'h00));
        chk("mid rst ovf", 32'(overflow), 32'(1'b0));
        chk("mid rst ack", 32'(ack_tx), 32'(1'b1));
        chk("mid rst frame cnt", 32'(frame_cnt), 32'(16'd0));
        chk("mid rst sync err", 32'(sync_err_cnt), 32'(16'd0));
        chk("mid rst state", 32'(state), 32'(3'd0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_idle(8);
        chk("mid rst exp empty", 32'(exp_q.size()), 32'(0));

        build_frame(8'h70);
        model_frame(FB);
        send_range(0, SB + FB);
        send_idle(8);
        chk("final frame cnt", 32'(frame_cnt), 32'(16'd1));
        chk("final exp empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otn_frame_rx.md
Name: otn_frame_rx

Overview:
Parametrised successor of the serial OTN frame receiver. It oversamples the incoming serial line with mid-bit phase alignment and hunts for a configurable frame-start pattern. Payload bytes go out on a valid/ready stream with SOF/EOF markers, and an optional ARQ good/bad ack symbol is returned on the ack line. It sits between the board serial input and the demapper, and adds framing statistics plus a CRC-response timeout.

Parameters:
OVERSAMPLE, 20, i_sample_en ticks per bit (>=4, even)
SYNC_BYTES, 6, frame-start pattern length in bytes (2..8)
SYNC_PATTERN, 64'h0000F6F6F6282828, pattern, right-justified, first byte = most significant used byte
FRAME_BYTES, 4160, payload bytes per frame (>=2)
CRC_TIMEOUT, 1024, i_clk cycles to wait for CRC verdict
CNT_W, 16, width of status counters

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_sample_en  in  1  oversample tick
i_serial_rx  in  1  asynchronous serial line, idle high
i_arq_en  in  1  ARQ enable value
i_arq_en_valid  in  1  load i_arq_en
i_crc_err  in  1  CRC verdict, 1 = bad
i_crc_err_valid  in  1  verdict strobe
o_data  out  8  payload byte
o_valid  out  1  o_data valid
o_sof  out  1  first payload byte (qualified by o_valid)
o_eof  out  1  last payload byte (qualified by o_valid)
i_ready  in  1  downstream accept
o_ack_tx  out  1  ack line, idle high
o_state  out  3  current FSM state
o_frame_cnt  out  CNT_W  completed frames
o_sync_err_cnt  out  CNT_W  aborted sync attempts
o_overflow  out  1  sticky byte-drop flag

Behaviour:
- Reset values: o_valid/o_sof/o_eof/o_overflow=0, o_ack_tx=1, counters=0, o_data=0, state=HUNT, arq_en=0. Reset mid-frame aborts with no output.
- Input: 2-flop synchronizer. Bit phase counter 0..OVERSAMPLE-1 advances on i_sample_en. In HUNT, each synchronized edge clears the counter. Bit strobe fires when the counter reaches OVERSAMPLE/2-1. Shift is MSB-first into an 8-bit register.
- States: HUNT=0, SYNC=1, DATA=2, WAIT_CRC=3, ACK=4.
- HUNT: on every bit strobe, compare the shift register to sync byte 0. On match go to SYNC with bit count=0.
- SYNC: after each 8 bits, compare against the next sync byte.
  - Mismatch -> HUNT, o_sync_err_cnt+1, saturating.
  - Last byte matched -> DATA.
  - Sync bytes are never output.
- DATA: each completed byte is presented on o_data/o_valid one cycle after its 8th bit strobe.
  - o_sof is set on byte 0 and o_eof on byte FRAME_BYTES-1.
  - The byte counter is $clog2(FRAME_BYTES) wide.
  - After the last byte, o_frame_cnt+1, wrapping. Next state is WAIT_CRC if arq_en, else HUNT.
  - An i_arq_en_valid in that same cycle takes effect for this decision.
- Output handshake: o_valid is held with stable data and flags until i_ready. If a new byte completes while o_valid && !i_ready, the new byte is dropped, o_overflow=1 until reset, and the frame still counts. Stream output continues in any state until accepted.
- WAIT_CRC: i_crc_err_valid selects bad if i_crc_err=1, else good, then go to ACK. If CRC_TIMEOUT cycles elapse with no verdict, a bad ack is sent. A verdict on the timeout cycle wins.
- ACK: the bit counter restarts at entry. Emit, one bit period each: 0 (start), 1 good / 0 bad, 0 (stop), then 1. Then go to HUNT.
- i_arq_en_valid is honoured in every state.
- i_sample_en low freezes bit timing only.

Decomposition:
- Package otn_rx_pkg: state localparams, default SYNC_PATTERN, ack bit constants (START=0, STOP=0, IDLE=1), and a function extracting sync byte n.
- Sub-module otn_bit_timer: synchronizer, phase counter, edge realign in HUNT, and bit-strobe generation. Outputs rx_bit, bit_stb, restart input.

Test Plan:
- OVERSAMPLE=4, FRAME_BYTES=8, ARQ off: send F6F6F6282828 followed by 00..07 -> 8 beats 00..07, o_sof on 00, o_eof on 07, o_frame_cnt=1, o_ack_tx stays 1.
- Broken sync F6F6F6 28 AA -> return to HUNT, o_sync_err_cnt=1, no o_valid. A following good frame is received correctly.
- ARQ on, i_crc_err_valid=1 with i_crc_err=0 after the frame -> o_ack_tx sequence 0,1,0,1, each 4 sample ticks, then HUNT. With i_crc_err=1 -> 0,0,0,1.
- ARQ on, no verdict, CRC_TIMEOUT=16 -> bad ack starts 16 cycles after WAIT_CRC entry.
- i_ready=0 for the whole frame -> only byte 00 presented, o_overflow=1. Release i_ready -> 00 accepted, o_valid drops.
- Assert i_rst at payload byte 3 -> all outputs at reset values the next cycle, o_frame_cnt=0, state=HUNT.
